// File: rtl/instr_fetch_seq.sv
// Instruction-fetch sequencer: latches the PC into the MAR, strobes incPC once,
// runs a read handshake with instruction memory and loads the instruction register.
module instr_fetch_seq #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [31:0]       pc_in,
    output logic              incPC,
    output logic [ADDR_W-1:0] mar_out,
    output logic              mem_read,
    input  logic              mem_ready,
    input  logic [31:0]       mem_data,
    output logic [31:0]       ir_out,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_done,
    output logic              fetch_err
);

    // Counter holds TIMEOUT+1 so the comparison below can never alias after a wrap.
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_inc;
    logic             w_timeout_hit;
    logic             w_unused_pc_hi;

    assign w_wait_cnt_inc = r_wait_cnt + CNT_W'(1);
    assign w_timeout_hit  = (w_wait_cnt_inc == CNT_W'(TIMEOUT));
    assign w_unused_pc_hi = ^pc_in[31:ADDR_W];

    // Fetch FSM; every output is a register loaded with the value for the next state.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= {CNT_W{1'b0}};
            mar_out    <= {ADDR_W{1'b0}};
            ir_out     <= 32'h0000_0000;
            incPC      <= 1'b0;
            mem_read   <= 1'b0;
            ir_valid   <= 1'b0;
            busy       <= 1'b0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_REQ;
                        r_wait_cnt <= {CNT_W{1'b0}};
                        mar_out    <= pc_in[ADDR_W-1:0];
                        ir_valid   <= 1'b0;
                        incPC      <= 1'b1;
                        mem_read   <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_REQ: begin
                    r_state  <= S_WAIT;
                    incPC    <= 1'b0;
                    mem_read <= 1'b1;
                    busy     <= 1'b1;
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        r_state    <= S_DONE;
                        ir_out     <= mem_data;
                        ir_valid   <= 1'b1;
                        mem_read   <= 1'b0;
                        fetch_done <= 1'b1;
                    end else if (w_timeout_hit) begin
                        r_state    <= S_ERR;
                        r_wait_cnt <= w_wait_cnt_inc;
                        mem_read   <= 1'b0;
                        busy       <= 1'b0;
                        ir_valid   <= 1'b0;
                        fetch_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= w_wait_cnt_inc;
                    end
                end
                // The DONE exit edge doubles as the acceptance point for the next
                // request, which is what makes a 3-cycle back-to-back fetch period.
                S_DONE: begin
                    fetch_done <= 1'b0;
                    if (start) begin
                        r_state    <= S_REQ;
                        r_wait_cnt <= {CNT_W{1'b0}};
                        mar_out    <= pc_in[ADDR_W-1:0];
                        ir_valid   <= 1'b0;
                        incPC      <= 1'b1;
                        mem_read   <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        r_state    <= S_IDLE;
                        busy       <= 1'b0;
                    end
                end
                S_ERR: begin
                    r_state    <= S_ERR;
                    incPC      <= 1'b0;
                    mem_read   <= 1'b0;
                    busy       <= 1'b0;
                    ir_valid   <= 1'b0;
                    fetch_done <= 1'b0;
                    fetch_err  <= 1'b1;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wait_cnt <= {CNT_W{1'b0}};
                    incPC      <= 1'b0;
                    mem_read   <= 1'b0;
                    ir_valid   <= 1'b0;
                    busy       <= 1'b0;
                    fetch_done <= 1'b0;
                    fetch_err  <= 1'b0;
                end
            endcase
        end
    end

endmodule
